gb_bus_sync: RTL

- Upstream front end of the cartridge mapper. It samples the asynchronous Game Boy cartridge bus (wr, rd, cs, addr, data) into the FPGA clk domain.
- Write cycles are filtered for glitches and reduced to single clean write events, each carrying a stable address/data pair.
- Events are buffered in a small FIFO with a valid/ready handshake, which the bank-switch logic drains.
- The block also exports a synchronized read-active level and address for the ROM read path.

---
 rtl/gb_bus_sync.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/gb_bus_sync.sv
// gb_bus_sync: cartridge bus front end for the mapper.
// Brings the asynchronous GB cartridge bus into the clk domain, turns each
// wr strobe into at most one clean write event (address/data/cs), queues the
// events in a small FIFO for the bank-switch logic and exports a registered
// read-active level plus address for the ROM read path.
module gb_bus_sync #(
    parameter int SYNC_STAGES = 2,   // synchronizer depth, 2..4
    parameter int MIN_LOW     = 4,   // wr low cycles needed to arm a write
    parameter int STABLE      = 2,   // identical samples needed to capture
    parameter int FIFO_DEPTH  = 4    // event FIFO entries, power of two >= 2
) (
    input  logic        clk,
    input  logic        rst,         // asynchronous, active low
    input  logic        wr,
    input  logic        rd,
    input  logic        cs,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [15:0] evt_addr,
    output logic [7:0]  evt_data,
    output logic        evt_cs,
    output logic        rd_active,
    output logic [15:0] rd_addr,
    output logic        overflow,
    output logic        glitch
);

    // one bus sample: {wr, rd, cs, addr, data}
    localparam int BUS_W  = 27;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LCNT_W = $clog2(MIN_LOW + 1);
    localparam int SCNT_W = $clog2(STABLE + 1);

    // strobes idle high, buses idle at zero
    localparam logic [BUS_W-1:0] BUS_IDLE = {1'b1, 1'b1, 1'b1, 16'h0000, 8'h00};

    // the part of a sample that a write event carries
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        cs;
    } evt_t;

    localparam evt_t EVT_IDLE = '{addr: 16'h0000, data: 8'h00, cs: 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        ARMED
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q;

    // every bus bit walks through SYNC_STAGES flops before it is used
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{BUS_IDLE}};
        end else begin
            sync_q[0] <= {wr, rd, cs, addr, data_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic        s_wr;
    logic        s_rd;
    logic        s_cs;
    logic [15:0] s_addr;
    logic [7:0]  s_data;
    evt_t        s_evt;

    assign {s_wr, s_rd, s_cs, s_addr, s_data} = sync_q[SYNC_STAGES-1];
    assign s_evt = '{addr: s_addr, data: s_data, cs: s_cs};

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic        rd_active_q;
    logic [15:0] rd_addr_q;

    // ROM reads are rd low in the lower half of the address space
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_active_q <= 1'b0;
            rd_addr_q   <= 16'h0000;
        end else begin
            rd_active_q <= ~s_rd & ~s_addr[15];
            rd_addr_q   <= s_addr;
        end
    end

    assign rd_active = rd_active_q;
    assign rd_addr   = rd_addr_q;

    // ------------------------------------------------------------------
    // Write qualification FSM
    // ------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [LCNT_W-1:0]   low_cnt_q,  low_cnt_d;
    logic [SCNT_W-1:0]   stab_cnt_q, stab_cnt_d;
    logic [SCNT_W-1:0]   stab_next;
    logic                qual;
    evt_t                prev_q;
    evt_t                cap_q,      cap_d;
    logic                cap_vld_q,  cap_vld_d;
    logic                push_q,     push_d;
    evt_t                push_evt_q, push_evt_d;
    logic                glitch_q;
    logic                glitch_set;

    // length of the current run of identical samples, saturating at STABLE
    always_comb begin
        stab_next = SCNT_W'(1);
        if (s_evt == prev_q) begin
            if (stab_cnt_q >= SCNT_W'(STABLE)) begin
                stab_next = SCNT_W'(STABLE);
            end else begin
                stab_next = stab_cnt_q + SCNT_W'(1);
            end
        end
    end

    assign qual = (stab_next >= SCNT_W'(STABLE));

    // FSM state, counters, capture register and the one-cycle push request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            low_cnt_q  <= '0;
            stab_cnt_q <= '0;
            prev_q     <= EVT_IDLE;
            cap_q      <= EVT_IDLE;
            cap_vld_q  <= 1'b0;
            push_q     <= 1'b0;
            push_evt_q <= EVT_IDLE;
            glitch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_cnt_q  <= low_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            prev_q     <= s_evt;
            cap_q      <= cap_d;
            cap_vld_q  <= cap_vld_d;
            push_q     <= push_d;
            push_evt_q <= push_evt_d;
            glitch_q   <= glitch_q | glitch_set;
        end
    end

    // next-state: count the low time, then track stability until wr rises
    always_comb begin
        state_d    = state_q;
        low_cnt_d  = low_cnt_q;
        stab_cnt_d = stab_cnt_q;
        cap_d      = cap_q;
        cap_vld_d  = cap_vld_q;
        push_d     = 1'b0;
        push_evt_d = push_evt_q;
        glitch_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (!s_wr) begin
                    if (MIN_LOW <= 1) begin
                        state_d    = ARMED;
                        stab_cnt_d = '0;
                        cap_vld_d  = 1'b0;
                    end else begin
                        state_d   = LOW;
                        low_cnt_d = LCNT_W'(1);
                    end
                end
            end

            LOW: begin
                if (s_wr) begin
                    // released before the minimum low time
                    glitch_set = 1'b1;
                    state_d    = IDLE;
                end else if (32'(low_cnt_q) + 1 >= MIN_LOW) begin
                    state_d    = ARMED;
                    stab_cnt_d = '0;
                    cap_vld_d  = 1'b0;
                end else begin
                    low_cnt_d = low_cnt_q + LCNT_W'(1);
                end
            end

            ARMED: begin
                // the sample seen with the rising edge still counts
                stab_cnt_d = stab_next;
                if (qual) begin
                    cap_d     = s_evt;
                    cap_vld_d = 1'b1;
                end
                if (s_wr) begin
                    if (qual || cap_vld_q) begin
                        push_d     = 1'b1;
                        push_evt_d = qual ? s_evt : cap_q;
                    end else begin
                        glitch_set = 1'b1;
                    end
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign glitch = glitch_q;

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    evt_t             mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wptr_q;
    logic [PTR_W:0]   rptr_q;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             overflow_q;
    evt_t             head;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign pop     = ~empty & evt_ready;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok = push_q & (~full | pop);

    // storage, wrapping pointers and the sticky drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= EVT_IDLE;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q[PTR_W-1:0]] <= push_evt_q;
                wptr_q                   <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push_q && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign head      = mem_q[rptr_q[PTR_W-1:0]];
    assign evt_valid = ~empty;
    assign evt_addr  = head.addr;
    assign evt_data  = head.data;
    assign evt_cs    = head.cs;
    assign overflow  = overflow_q;

endmodule
